// File: rtl/corr_multi_counter_if.sv
// Byte-stream valid/ready link between corr_multi_counter and the host packet FIFO.
// The master drives data/valid and the slave returns ready.
interface corr_multi_counter_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/corr_multi_counter.sv
// Multi-pair windowed correlation counter with a byte-packet output stream.
// Optional feature macro: CORR_MULTI_COUNTER_CHECKSUM_EN appends an XOR checksum byte.
module corr_multi_counter #(
  parameter int  N_CH                  = 8,
  parameter int  N_PAIRS               = 2,
  parameter int  MAX_WINDOW_LENGTH_EXP = 16,
  parameter int  MAX_SAMPLE_PERIOD_EXP = 15,
  localparam int SEL_W = $clog2(N_CH),
  localparam int CNT_W = MAX_WINDOW_LENGTH_EXP + 1,
  localparam int LEN_W = $clog2(MAX_WINDOW_LENGTH_EXP + 1),
  localparam int PER_W = $clog2(MAX_SAMPLE_PERIOD_EXP + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cg,
  input  logic [N_CH-1:0]          i_x,
  input  logic [N_PAIRS*SEL_W-1:0] i_selX,
  input  logic [N_PAIRS*SEL_W-1:0] i_selY,
  input  logic [LEN_W-1:0]         i_windowLengthExp,
  input  logic [PER_W-1:0]         i_samplePeriodExp,
  input  logic                     i_clear,
  corr_multi_counter_if.master     pkt,
  output logic                     o_overflow,
  input  logic                     i_overflowClr,
  output logic [7:0]               o_winNum
);

`ifdef CORR_MULTI_COUNTER_CHECKSUM_EN
  localparam int PKT_LEN = 2 + 4*N_PAIRS;
`else
  localparam int PKT_LEN = 1 + 4*N_PAIRS;
`endif
  localparam int T_W   = MAX_WINDOW_LENGTH_EXP;
  localparam int SP_W  = MAX_SAMPLE_PERIOD_EXP;
  localparam int IDX_W = $clog2(PKT_LEN);

  localparam logic [T_W-1:0]   T_ONES   = '1;
  localparam logic [SP_W-1:0]  SP_ONES  = '1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PKT_LEN - 1);

  typedef enum logic {IDLE, SEND} state_t;

  // Count c over a 2**l window mapped to a byte; a fully-set window saturates to FF.
  function automatic logic [7:0] scale_byte(input logic [CNT_W-1:0] c,
                                            input logic [LEN_W-1:0] l);
    logic [CNT_W-1:0] full;
    logic [CNT_W+7:0] wide;
    full = CNT_W'(1) << l;
    if (l >= LEN_W'(8)) wide = {8'd0, c} >> (l - LEN_W'(8));
    else                wide = {8'd0, c} << (LEN_W'(8) - l);
    return (c == full) ? 8'hFF : wide[7:0];
  endfunction

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] c, input logic b);
    return c + {{(CNT_W-1){1'b0}}, b};
  endfunction

  state_t           state, state_n;
  logic [SP_W-1:0]  sp_ctr;
  logic [T_W-1:0]   t;
  logic [LEN_W-1:0] len_exp;
  logic [PER_W-1:0] per_exp;
  logic [SP_W-1:0]  sp_mask;
  logic [T_W-1:0]   t_mask;
  logic             strobe, win_end, accept, last_acc, take_snap, drop;
  logic [IDX_W-1:0] idx;

  logic [CNT_W-1:0] cnt_x [N_PAIRS];
  logic [CNT_W-1:0] cnt_y [N_PAIRS];
  logic [CNT_W-1:0] cnt_i [N_PAIRS];
  logic [CNT_W-1:0] cnt_s [N_PAIRS];
  logic [CNT_W-1:0] nx_x  [N_PAIRS];
  logic [CNT_W-1:0] nx_y  [N_PAIRS];
  logic [CNT_W-1:0] nx_i  [N_PAIRS];
  logic [CNT_W-1:0] nx_s  [N_PAIRS];
  logic [N_PAIRS-1:0] smp_x, smp_y;

  logic [7:0] snap    [PKT_LEN];
  logic [7:0] pkt_reg [PKT_LEN];

  assign len_exp = (int'(i_windowLengthExp) > MAX_WINDOW_LENGTH_EXP) ?
                   LEN_W'(MAX_WINDOW_LENGTH_EXP) : i_windowLengthExp;
  assign per_exp = (int'(i_samplePeriodExp) > MAX_SAMPLE_PERIOD_EXP) ?
                   PER_W'(MAX_SAMPLE_PERIOD_EXP) : i_samplePeriodExp;
  assign sp_mask = SP_ONES >> (MAX_SAMPLE_PERIOD_EXP - int'(per_exp));
  assign t_mask  = T_ONES  >> (MAX_WINDOW_LENGTH_EXP - int'(len_exp));

  // ">=" rather than "==" so a shrinking L or P mid-window cannot stall the stream.
  assign strobe    = (sp_ctr >= sp_mask);
  assign win_end   = i_cg && strobe && (t >= t_mask) && !i_clear;
  assign accept    = i_cg && (state == SEND) && pkt.ready;
  assign last_acc  = accept && (idx == IDX_LAST);
  assign take_snap = win_end && ((state == IDLE) || last_acc);
  assign drop      = win_end && !take_snap;

  always_comb begin
    for (int p = 0; p < N_PAIRS; p++) begin
      smp_x[p] = i_x[i_selX[p*SEL_W +: SEL_W]];
      smp_y[p] = i_x[i_selY[p*SEL_W +: SEL_W]];
      nx_x[p]  = bump(cnt_x[p], smp_x[p]);
      nx_y[p]  = bump(cnt_y[p], smp_y[p]);
      nx_i[p]  = bump(cnt_i[p], smp_x[p] & smp_y[p]);
      nx_s[p]  = bump(cnt_s[p], smp_x[p] ^ smp_y[p]);
    end
  end

  // Snapshot uses the post-increment counts so the window's final sample is included.
`ifdef CORR_MULTI_COUNTER_CHECKSUM_EN
  logic [7:0] csum;
`endif
  always_comb begin
    for (int k = 0; k < PKT_LEN; k++) snap[k] = 8'd0;
    snap[0] = o_winNum + 8'd1;
    for (int p = 0; p < N_PAIRS; p++) begin
      snap[1 + 4*p] = scale_byte(nx_x[p], len_exp);
      snap[2 + 4*p] = scale_byte(nx_y[p], len_exp);
      snap[3 + 4*p] = scale_byte(nx_i[p], len_exp);
      snap[4 + 4*p] = scale_byte(nx_s[p], len_exp);
    end
`ifdef CORR_MULTI_COUNTER_CHECKSUM_EN
    csum = 8'd0;
    for (int k = 0; k < PKT_LEN - 1; k++) csum = csum ^ snap[k];
    snap[PKT_LEN-1] = csum;
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sp_ctr <= '0;
      t      <= '0;
    end else if (i_cg) begin
      if (i_clear || strobe) sp_ctr <= '0;
      else                   sp_ctr <= sp_ctr + SP_W'(1);
      if (i_clear)           t <= '0;
      else if (strobe)       t <= (t >= t_mask) ? '0 : t + T_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int p = 0; p < N_PAIRS; p++) begin
        cnt_x[p] <= '0;
        cnt_y[p] <= '0;
        cnt_i[p] <= '0;
        cnt_s[p] <= '0;
      end
    end else if (i_cg) begin
      for (int p = 0; p < N_PAIRS; p++) begin
        if (i_clear || win_end) begin
          cnt_x[p] <= '0;
          cnt_y[p] <= '0;
          cnt_i[p] <= '0;
          cnt_s[p] <= '0;
        end else if (strobe) begin
          cnt_x[p] <= nx_x[p];
          cnt_y[p] <= nx_y[p];
          cnt_i[p] <= nx_i[p];
          cnt_s[p] <= nx_s[p];
        end
      end
    end
  end

  // winNum counts dropped windows too, so the host sees gaps in the sequence.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_winNum   <= 8'd0;
      o_overflow <= 1'b0;
      idx        <= '0;
      for (int k = 0; k < PKT_LEN; k++) pkt_reg[k] <= 8'd0;
    end else if (i_cg) begin
      if (win_end) o_winNum <= o_winNum + 8'd1;
      if (drop)               o_overflow <= 1'b1;
      else if (i_overflowClr) o_overflow <= 1'b0;
      if (take_snap || last_acc) idx <= '0;
      else if (accept)           idx <= idx + IDX_W'(1);
      if (take_snap) begin
        for (int k = 0; k < PKT_LEN; k++) pkt_reg[k] <= snap[k];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    pkt.valid = 1'b0;
    case (state)
      IDLE: if (take_snap) state_n = SEND;
      SEND: begin
        pkt.valid = 1'b1;
        if (last_acc && !take_snap) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign pkt.data = pkt_reg[idx];

endmodule

// File: tb/tb_corr_multi_counter.sv
// Scoreboard bench for corr_multi_counter: stimulus pushes expected packet bytes,
// a negedge monitor pops and compares them on every handshake and checks stall stability.
module tb_corr_multi_counter;
  localparam int N_CH    = 8;
  localparam int N_PAIRS = 2;
  localparam int SEL_W   = 3;
`ifdef CORR_MULTI_COUNTER_CHECKSUM_EN
  localparam int PKT_LEN = 2 + 4*N_PAIRS;
`else
  localparam int PKT_LEN = 1 + 4*N_PAIRS;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     cg = 1'b1;
  logic                     clear = 1'b0;
  logic                     ovf_clr = 1'b0;
  logic [N_CH-1:0]          x = '0;
  logic [N_PAIRS*SEL_W-1:0] sel_x = '0;
  logic [N_PAIRS*SEL_W-1:0] sel_y = '0;
  logic [4:0]               wl = 5'd0;
  logic [3:0]               sp = 4'd0;
  logic                     overflow;
  logic [7:0]               win_num;

  corr_multi_counter_if pkt_bus();

  always #5 clk = ~clk;

  corr_multi_counter dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_cg              (cg),
    .i_x               (x),
    .i_selX            (sel_x),
    .i_selY            (sel_y),
    .i_windowLengthExp (wl),
    .i_samplePeriodExp (sp),
    .i_clear           (clear),
    .pkt               (pkt_bus),
    .o_overflow        (overflow),
    .i_overflowClr     (ovf_clr),
    .o_winNum          (win_num)
  );

  int         passed = 0;
  int         total  = 0;
  logic [7:0] exp_q[$];
  logic       stalled = 1'b0;
  logic [7:0] held = 8'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Bytes given MSB-first: X0,Y0,I0,S0,X1,Y1,I1,S1.
  task automatic push_pkt(input logic [7:0] wn, input logic [63:0] b);
    logic [7:0] cs;
    logic [7:0] v;
    cs = wn;
    exp_q.push_back(wn);
    for (int k = 7; k >= 0; k--) begin
      v = b[k*8 +: 8];
      cs = cs ^ v;
      exp_q.push_back(v);
    end
`ifdef CORR_MULTI_COUNTER_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endtask

  task automatic do_reset();
    exp_q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_valid", pkt_bus.valid, 0);
    check("rst_data", pkt_bus.data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_winnum", win_num, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      stalled = 1'b0;
    end else if (cg) begin
      if (stalled) begin
        check("stall_valid", pkt_bus.valid, 1);
        check("stall_data", pkt_bus.data, held);
      end
      if (pkt_bus.valid && pkt_bus.ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_byte: got %0h required no byte", pkt_bus.data);
        end else begin
          e = exp_q.pop_front();
          check("pkt_byte", pkt_bus.data, e);
        end
      end
      stalled = pkt_bus.valid && !pkt_bus.ready;
      held    = pkt_bus.data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    pkt_bus.ready = 1'b1;

    // Constant ones on ch0/ch1, L=8, P=0.
    wl = 5'd8; sp = 4'd0; x = 8'b0000_0011;
    sel_x = {3'd2, 3'd0}; sel_y = {3'd3, 3'd1};
    do_reset();
    push_pkt(8'h01, {8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
    wait_drain(400, "t1_drain");
    check("t1_winnum", win_num, 1);
    check("t1_overflow", overflow, 0);

    // L=10, P=2: X toggles per strobe, Y=0; pair 1 uses selX==selY on a constant 1.
    wl = 5'd10; sp = 4'd2; x = 8'b0000_0100;
    sel_x = {3'd2, 3'd0}; sel_y = {3'd2, 3'd1};
    do_reset();
    push_pkt(8'h01, {8'h80, 8'h00, 8'h00, 8'h80, 8'hFF, 8'hFF, 8'hFF, 8'h00});
    for (int i = 0; i < 4400 && exp_q.size() != 0; i++) begin
      if (i % 4 == 0) x[0] = ~x[0];
      @(posedge clk); #1;
    end
    wait_drain(1, "t2_drain");
    check("t2_winnum", win_num, 1);

    // L=0, ready held low across three windows.
    wl = 5'd0; sp = 4'd0; x = 8'b0000_0001;
    sel_x = {3'd0, 3'd0}; sel_y = {3'd0, 3'd1};
    pkt_bus.ready = 1'b0; cg = 1'b0;
    do_reset();
    push_pkt(8'h01, {8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00});
    cg = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cg = 1'b0; sp = 4'd15;
    check("t3_winnum", win_num, 3);
    check("t3_overflow", overflow, 1);
    check("t3_valid_held", pkt_bus.valid, 1);
    @(posedge clk); #1;
    cg = 1'b1; pkt_bus.ready = 1'b1;
    wait_drain(20, "t3_drain");
    check("t3_overflow_sticky", overflow, 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check("t3_overflow_clr", overflow, 0);

    // Random 50% ready, L=8, P=1.
    wl = 5'd8; sp = 4'd1; x = 8'b0000_0110;
    sel_x = {3'd2, 3'd0}; sel_y = {3'd0, 3'd1};
    do_reset();
    push_pkt(8'h01, {8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF});
    for (int i = 0; i < 800 && exp_q.size() != 0; i++) begin
      pkt_bus.ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    pkt_bus.ready = 1'b1;
    wait_drain(1, "t4_drain");
    check("t4_winnum", win_num, 1);

    // Clear after 5 strobes of a 16-strobe window; only post-clear samples count.
    wl = 5'd4; sp = 4'd0; x = 8'b0000_0000;
    sel_x = {3'd1, 3'd0}; sel_y = {3'd1, 3'd1};
    do_reset();
    push_pkt(8'h01, {8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00});
    repeat (5) @(posedge clk);
    #1;
    x = 8'b0000_0001; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    wait_drain(28, "t5_drain");
    check("t5_winnum", win_num, 1);
    check("t5_overflow", overflow, 0);
    cg = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
